// File: rtl/prim_arbiter_wrr.sv
// prim_arbiter_wrr: N:1 weighted round-robin arbiter with burst weights and
// grant locking.
//
// Ownership rotates round-robin. A winner with weight w keeps the grant for
// w+1 consecutive transfers. A selection that is presented to the sink but not
// yet accepted is frozen until the handshake (EnLock=1).
//
// Ports
//   clk_i     clock
//   rst_i     synchronous active-high reset; forces all outputs to zero
//   req_i     [N]      request per port
//   data_i    [N*DW]   data per port (ignored when EnDataPort=0)
//   weight_i  [N*WW]   burst weight per port, sampled at burst start
//   gnt_o     [N]      one-hot grant, asserted on the transfer cycle only
//   idx_o     [IdxW]   index of the selected port
//   valid_o            a selection is presented
//   data_o    [DW]     data of the selected port (all ones when EnDataPort=0)
//   ready_i            sink ready
module prim_arbiter_wrr #(
  parameter int unsigned N          = 8,
  parameter int unsigned DW         = 32,
  parameter int unsigned WW         = 4,
  parameter bit          EnDataPort = 1'b1,
  parameter bit          EnLock     = 1'b1,
  localparam int unsigned IdxW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    req_i,
  input  logic [N*DW-1:0] data_i,
  input  logic [N*WW-1:0] weight_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o,
  output logic [DW-1:0]   data_o,
  input  logic            ready_i
);

  // First requesting index in cyclic order ptr+1, ptr+2, ..., ptr (mod N).
  // Returns 0 when nothing requests.
  function automatic logic [IdxW-1:0] rr_search(input logic [N-1:0]    req,
                                                 input logic [IdxW-1:0] ptr);
    logic [IdxW-1:0] res;
    logic            found;
    logic [IdxW:0]   j;
    res   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      j = {1'b0, ptr} + (IdxW+1)'(k);
      if (j >= (IdxW+1)'(N)) begin
        j = j - (IdxW+1)'(N);
      end
      if (!found && req[j[IdxW-1:0]]) begin
        found = 1'b1;
        res   = j[IdxW-1:0];
      end
    end
    return res;
  endfunction

  generate
    if (N == 1) begin : g_bypass
      // Single requester: pure pass-through, no state.
      logic unused_bypass;
      assign unused_bypass = ^{clk_i, weight_i};

      assign valid_o = ~rst_i & req_i[0];
      assign gnt_o   = valid_o & ready_i;
      assign idx_o   = '0;

      if (EnDataPort) begin : g_data
        assign data_o = rst_i ? '0 : data_i;
      end else begin : g_nodata
        logic unused_data;
        assign unused_data = ^data_i;
        assign data_o      = rst_i ? '0 : '1;
      end
    end else begin : g_arb
      logic [IdxW-1:0] ptr_q;
      logic [WW-1:0]   credit_q;
      logic            burst_q;
      logic            locked_q;
      logic [IdxW-1:0] lock_idx_q;
      logic [IdxW-1:0] winner;
      logic [WW-1:0]   weight_arr [N];
      logic            valid_raw;
      logic            hs;
      logic            new_burst;

      for (genvar k = 0; k < N; k++) begin : g_unpack
        assign weight_arr[k] = weight_i[k*WW +: WW];
      end

      // A frozen selection beats an ongoing burst, which beats rotation.
      always_comb begin
        if (locked_q) begin
          winner = lock_idx_q;
        end else if (burst_q && req_i[ptr_q]) begin
          winner = ptr_q;
        end else begin
          winner = rr_search(req_i, ptr_q);
        end
      end

      // Under lock only the frozen requester counts; if it drops, valid falls.
      assign valid_raw = locked_q ? req_i[lock_idx_q] : |req_i;
      assign hs        = valid_raw & ready_i;
      // Re-winning the owner after its burst ended is a fresh burst too.
      assign new_burst = (winner != ptr_q) || !burst_q;

      assign valid_o = ~rst_i & valid_raw;
      assign idx_o   = rst_i ? '0 : winner;
      assign gnt_o   = rst_i ? '0 : ((N'(1) << winner) & {N{hs}});

      if (EnDataPort) begin : g_data
        logic [DW-1:0] data_arr [N];
        for (genvar k = 0; k < N; k++) begin : g_dunpack
          assign data_arr[k] = data_i[k*DW +: DW];
        end
        assign data_o = rst_i ? '0 : data_arr[winner];
      end else begin : g_nodata
        logic unused_data;
        assign unused_data = ^data_i;
        assign data_o      = rst_i ? '0 : '1;
      end

      // ptr_q resets to N-1 so the very first search begins at port 0.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          ptr_q    <= IdxW'(N - 1);
          credit_q <= '0;
          burst_q  <= 1'b0;
        end else if (hs) begin
          if (new_burst) begin
            ptr_q    <= winner;
            credit_q <= weight_arr[winner];
            burst_q  <= (weight_arr[winner] != '0);
          end else begin
            credit_q <= credit_q - 1'b1;
            burst_q  <= (credit_q != WW'(1));
          end
        end else if (!req_i[ptr_q] && !locked_q) begin
          // Owner walked away: the rest of its credit is forfeited.
          burst_q <= 1'b0;
        end
      end

      if (EnLock) begin : g_lock
        // Presented-but-not-accepted freezes the selection; a handshake or a
        // vanished locked request releases it on the next edge.
        always_ff @(posedge clk_i) begin
          if (rst_i) begin
            locked_q   <= 1'b0;
            lock_idx_q <= '0;
          end else begin
            locked_q <= valid_raw & ~ready_i;
            if (valid_raw && !ready_i) begin
              lock_idx_q <= winner;
            end
          end
        end
      end else begin : g_nolock
        assign locked_q   = 1'b0;
        assign lock_idx_q = '0;
      end

      a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(gnt_o));
      a_gnt_hs: assert property (@(posedge clk_i) disable iff (rst_i)
        (|gnt_o) |-> (valid_o && ready_i));
      a_hs_gnt: assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_o && ready_i) |-> (gnt_o[idx_o] && req_i[idx_o]));
      a_lock_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (locked_q && req_i[lock_idx_q]) |-> (idx_o == lock_idx_q));
      a_known: assert property (@(posedge clk_i)
        !$isunknown({gnt_o, idx_o, valid_o, data_o}));
    end
  endgenerate

endmodule

// File: doc/prim_arbiter_wrr.md
# prim_arbiter_wrr

Parametrised N:1 weighted round-robin arbiter with per-requester burst weights and grant locking. It is the next-generation counterpart to the fixed-priority arbiter and sits in front of shared TL-UL hosts, DMA ports and shared memory ports. Ownership rotates fairly, and each owner keeps the grant for a configurable number of consecutive transfers. Once a selection is presented to the sink, it stays stable until the sink accepts it.

## Interface
- N, 8, number of request ports (≥1)
- DW, 32, data width
- WW, 4, weight width; weight w grants w+1 consecutive transfers
- EnDataPort, 1, 0: data_i ignored, data_o tied to all-ones
- EnLock, 1, 1: hold the presented selection until handshake
- IdxW, localparam $clog2(N) (1 when N==1)
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- req_i  in  N  request per port
- data_i  in  N×DW  data per port
- weight_i  in  N×WW  burst weight per port (quasi-static)
- gnt_o  out  N  one-hot grant, asserted on transfer cycle only
- idx_o  out  IdxW  index of selected port
- valid_o  out  1  a selection is presented
- data_o  out  DW  data of selected port
- ready_i  in  1  sink ready

## Operation
- State registers:
  - ptr_q (IdxW): current owner.
  - credit_q (WW): transfers remaining in the burst after the current one.
  - burst_q: the owner continues its burst.
  - locked_q and lock_idx_q: the presented selection is frozen.
- Winner selection (combinational):
  - When locked_q=1: winner = lock_idx_q.
  - Else, when burst_q=1 and req_i[ptr_q]=1: winner = ptr_q.
  - Else: the winner is the first requesting index found by a cyclic search starting at ptr_q+1 mod N and ending at ptr_q.
- valid_o = locked_q ? req_i[lock_idx_q] : |req_i.
- idx_o = winner.
- data_o = data_i[winner].
- gnt_o = onehot(winner) & {N{valid_o & ready_i}}.
- When there is no request, idx_o=0 and data_o=data_i[0].
- On a handshake (valid_o & ready_i) that starts a new burst (winner ≠ ptr_q, or burst_q=0):
  - ptr_q ← winner
  - credit_q ← weight_i[winner]
  - burst_q ← (weight_i[winner] ≠ 0)
- On a handshake that continues a burst:
  - credit_q ← credit_q−1
  - burst_q ← (credit_q ≠ 1)
- Owner releases early: if req_i[ptr_q]=0 and locked_q=0, burst_q ← 0 in the same cycle. The remaining credit is forfeited.
- Lock (EnLock=1):
  - valid_o & ~ready_i sets locked_q ← 1 and lock_idx_q ← idx_o.
  - A handshake clears locked_q.
  - A locked requester that drops req_i is a protocol violation. valid_o falls, and locked_q clears on the next clock.
  - With EnLock=0, locked_q is tied to 0.
- weight_i is sampled only at burst start. Changes mid-burst take effect at the next burst.
- N==1 bypass, no state:
  - valid_o = req_i[0]
  - gnt_o[0] = valid_o & ready_i
  - idx_o = 0
- Reset values: ptr_q=N−1 (so the first search starts at port 0), credit_q=0, burst_q=0, locked_q=0, lock_idx_q=0.
- While rst_i=1, outputs are forced: valid_o=0, gnt_o=0, idx_o=0, data_o=0.

## Timing
- Zero-latency: a request and ready_i in the same cycle produce gnt_o in that cycle.
- All state updates on the rising edge of clk_i.
- Fairness: with all ports requesting and ready_i=1, every port receives weight+1 grants per rotation. Maximum wait = Σ(weight_i[k]+1) over the other ports.
- Wrap-around: the search from ptr_q=N−1 starts at 0. With ptr_q=k and only port k requesting, port k wins again and starts a new burst.
- Simultaneous last-credit handshake and new requests: the next cycle selects by rotation from ptr_q+1.
- rst_i asserted mid-burst or mid-lock: all state returns to reset values on that edge, and outputs are zero during that cycle.
- Assertions:
  - $onehot0(gnt_o)
  - gnt_o implies ready_i & valid_o
  - valid_o & ready_i implies gnt_o[idx_o] & req_i[idx_o]
  - under lock with req held, idx_o and data_o are stable until handshake
  - known outputs

## Test plan
- Weighted rotation: N=4, weights {0,2,0,1}, req_i=4'b1111, ready_i=1 from reset release → grant index sequence 0,1,1,1,2,3,3,0,1,…
- Lock: only req_i[2]=1, ready_i=0 for 3 cycles; req_i[0] rises in cycle 2 → idx_o=2 and data_o=data_i[2] held throughout. When ready_i=1: gnt_o=4'b0100, then idx_o=0 on the next cycle.
- Early release: port 1 at weight 3 drops req after 2 grants, while ports 1 and 3 otherwise request → next grant goes to 3. When port 1 later returns, it starts a fresh burst of 4.
- Wrap and single requester: only port 3 requests, weight 0, ready_i=1 → gnt_o=4'b1000 every cycle, with ptr_q remaining 3.
- Reset mid-burst: assert rst_i during port 1's second of 3 grants → outputs 0 that cycle. After release, with all ports requesting, the grant starts at port 0.
- EnLock=0 / EnDataPort=0 / N=1 builds: selection may change while ready_i=0, data_o is all ones, and the bypass yields gnt_o[0]=req_i[0]&ready_i.
